// File: rtl/instruction_stream_sequencer.sv
// instruction_stream_sequencer: program-memory instruction feeder for the cpu.
// Words are loaded into an internal synchronous RAM. On start they are issued
// one per cycle until a SENTINEL word is read. The block also supports stall,
// program repeat, abort, overrun detection and an issued-word counter.
// Ports:
//   clock_in, reset_n_in                    clock, asynchronous active-low reset
//   load_write_enable_in/address_in/data_in program write port (IDLE/DONE only)
//   start_in, abort_in, stall_in            run control and cpu back-pressure
//   repeat_count_in                         extra passes, latched at start
//   current_instruction_out, instruction_valid_out  issued word to the cpu
//   busy_out, done_out, overrun_out         run status
//   instruction_count_out                   words issued this run (saturating)
//   program_counter_out                     address of the word being fetched
// Optional: defining INSTR_BREAKPOINT_EN adds breakpoint_enable_in,
//   breakpoint_address_in, resume_in, breakpoint_hit_out and a BREAK state.
module instruction_stream_sequencer #(
    parameter int INSTR_WIDTH = 16,
    parameter int DEPTH = 256,
    parameter int COUNT_WIDTH = 16,
    parameter logic [INSTR_WIDTH-1:0] SENTINEL = 16'hFFFF,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTRUCTION = 16'h9000,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                   clock_in,
    input  logic                   reset_n_in,
    input  logic                   load_write_enable_in,
    input  logic [ADDR_WIDTH-1:0]  load_address_in,
    input  logic [INSTR_WIDTH-1:0] load_data_in,
    input  logic                   start_in,
    input  logic                   abort_in,
    input  logic                   stall_in,
    input  logic [7:0]             repeat_count_in,
`ifdef INSTR_BREAKPOINT_EN
    input  logic                   breakpoint_enable_in,
    input  logic [ADDR_WIDTH-1:0]  breakpoint_address_in,
    input  logic                   resume_in,
    output logic                   breakpoint_hit_out,
`endif
    output logic [INSTR_WIDTH-1:0] current_instruction_out,
    output logic                   instruction_valid_out,
    output logic                   busy_out,
    output logic                   done_out,
    output logic                   overrun_out,
    output logic [COUNT_WIDTH-1:0] instruction_count_out,
    output logic [ADDR_WIDTH-1:0]  program_counter_out
);
    typedef enum logic [2:0] {
        IDLE, PRIME, RUN, DONE
`ifdef INSTR_BREAKPOINT_EN
        , BREAK
`endif
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t state, state_n;
    logic [ADDR_WIDTH-1:0] pc, pc_n;
    logic [INSTR_WIDTH-1:0] instr, instr_n, rd_data;
    logic [INSTR_WIDTH-1:0] mem [DEPTH];
    logic valid, valid_n, done, done_n, over, over_n, last, last_n, issue;
    logic [COUNT_WIDTH-1:0] count, count_n;
    logic [7:0] rep, rep_n;
`ifdef INSTR_BREAKPOINT_EN
    logic bp_seen, bp_seen_n;
    assign breakpoint_hit_out = (state == BREAK);
`endif

    assign busy_out = (state != IDLE) && (state != DONE);
    assign current_instruction_out = instr;
    assign instruction_valid_out = valid;
    assign done_out = done;
    assign overrun_out = over;
    assign instruction_count_out = count;
    assign program_counter_out = pc;

    // The RAM is always addressed with the next pc, so rd_data lines up with pc.
    always_ff @(posedge clock_in) begin
        if (load_write_enable_in && !busy_out) mem[load_address_in] <= load_data_in;
        rd_data <= mem[pc_n];
    end

    always_comb begin
        state_n = state;
        pc_n = pc;
        instr_n = instr;
        valid_n = valid;
        done_n = done;
        over_n = over;
        count_n = count;
        rep_n = rep;
        last_n = last;
        issue = 1'b0;
`ifdef INSTR_BREAKPOINT_EN
        bp_seen_n = bp_seen;
`endif
        if (abort_in && busy_out) begin
            state_n = IDLE;
            instr_n = NOP_INSTRUCTION;
            valid_n = 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (start_in && !load_write_enable_in) begin
                    state_n = PRIME;
                    pc_n = '0;
                    rep_n = repeat_count_in;
                    done_n = 1'b0;
                    over_n = 1'b0;
                    count_n = '0;
                    last_n = 1'b0;
                end
                PRIME: state_n = RUN;
                // last marks that the word at LAST_ADDR went out; pc never wraps.
                RUN: if (last) begin
                    state_n = DONE;
                    done_n = 1'b1;
                    over_n = 1'b1;
                    instr_n = NOP_INSTRUCTION;
                    valid_n = 1'b0;
                end else if (!stall_in) begin
                    if (rd_data == SENTINEL) begin
                        instr_n = NOP_INSTRUCTION;
                        valid_n = 1'b0;
                        if (rep != 8'd0) begin
                            rep_n = rep - 8'd1;
                            pc_n = '0;
                            state_n = PRIME;
                        end else begin
                            state_n = DONE;
                            done_n = 1'b1;
                        end
`ifdef INSTR_BREAKPOINT_EN
                    end else if (breakpoint_enable_in && pc == breakpoint_address_in && !bp_seen) begin
                        state_n = BREAK;
                        instr_n = NOP_INSTRUCTION;
                        valid_n = 1'b0;
                        bp_seen_n = 1'b1;
`endif
                    end else begin
                        issue = 1'b1;
                    end
                end
`ifdef INSTR_BREAKPOINT_EN
                BREAK: if (resume_in) begin
                    state_n = RUN;
                    issue = 1'b1;
                end
`endif
                default: state_n = IDLE;
            endcase
            if (issue) begin
                instr_n = rd_data;
                valid_n = 1'b1;
                count_n = (&count) ? count : count + 1'b1;
                if (pc == LAST_ADDR) last_n = 1'b1;
                else pc_n = pc + 1'b1;
            end
        end
`ifdef INSTR_BREAKPOINT_EN
        // Re-arm the breakpoint once execution has moved off the address.
        if (pc_n != pc || !busy_out) bp_seen_n = 1'b0;
`endif
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state <= IDLE;
            pc <= '0;
            instr <= NOP_INSTRUCTION;
            valid <= 1'b0;
            done <= 1'b0;
            over <= 1'b0;
            count <= '0;
            rep <= '0;
            last <= 1'b0;
`ifdef INSTR_BREAKPOINT_EN
            bp_seen <= 1'b0;
`endif
        end else begin
            state <= state_n;
            pc <= pc_n;
            instr <= instr_n;
            valid <= valid_n;
            done <= done_n;
            over <= over_n;
            count <= count_n;
            rep <= rep_n;
            last <= last_n;
`ifdef INSTR_BREAKPOINT_EN
            bp_seen <= bp_seen_n;
`endif
        end
    end
endmodule
